// File: rtl/window_loader.sv
// window_loader: walks an IMG_H x IMG_W image in memory and feeds a SIZE x SIZE sliding window buffer.
// Define WIN_COLUMN_SCAN_EN for column-major traversal (shift-up, row reloads); default is row-major.
module window_loader #(
  parameter int SIZE   = 4,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [7:0]        memData,
  output logic              bufWrEn,
  output logic              bufShiftUp,
  output logic              bufShiftLeft,
  output logic [31:0]       bufIdxI,
  output logic [31:0]       bufIdxJ,
  output logic [7:0]        bufDataIn,
  input  logic [31:0]       rdIdxI,
  input  logic [31:0]       rdIdxJ,
  output logic              winValid,
  input  logic              winReady,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, FILL, VALID, SHIFT, LOAD, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] r0_q, r0_d, c0_q, c0_d, ci_q, ci_d, cj_q, cj_d, wi_q, wi_d, wj_q, wj_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic iss_q, iss_d, wr_q, wr_d, shift_q, shift_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic slide, next_line, last;
`ifdef WIN_COLUMN_SCAN_EN
  localparam bit COL = 1'b1;
  assign bufShiftUp   = shift_q;
  assign bufShiftLeft = 1'b0;
`else
  localparam bit COL = 1'b0;
  assign bufShiftUp   = 1'b0;
  assign bufShiftLeft = shift_q;
`endif
  // ci/cj index the element whose address is on the bus; iss_q marks that address as live
  always_comb begin
    slide     = COL ? r0_q + SIZE < IMG_H : c0_q + SIZE < IMG_W;
    next_line = COL ? c0_q + SIZE < IMG_W : r0_q + SIZE < IMG_H;
    last      = state_q == FILL ? (ci_q == SIZE - 1 && cj_q == SIZE - 1) : (COL ? cj_q : ci_q) == SIZE - 1;
    state_d   = state_q;
    r0_d      = r0_q;
    c0_d      = c0_q;
    ci_d      = ci_q;
    cj_d      = cj_q;
    iss_d     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = FILL;
        r0_d    = '0;
        c0_d    = '0;
        ci_d    = '0;
        cj_d    = '0;
        iss_d   = 1'b1;
      end
      FILL, LOAD: if (!iss_q) state_d = VALID;
      else if (!last) begin
        iss_d = 1'b1;
        ci_d  = state_q == LOAD ? (COL ? ci_q : ci_q + 1) : (cj_q == SIZE - 1 ? ci_q + 1 : ci_q);
        cj_d  = state_q == LOAD ? (COL ? cj_q + 1 : cj_q) : (cj_q == SIZE - 1 ? 32'd0 : cj_q + 1);
      end
      VALID: if (winReady) begin
        if (slide) state_d = SHIFT;
        else if (next_line) begin
          state_d = FILL;
          r0_d    = COL ? 32'd0 : r0_q + 1;
          c0_d    = COL ? c0_q + 1 : 32'd0;
          ci_d    = '0;
          cj_d    = '0;
          iss_d   = 1'b1;
        end else state_d = DONE;
      end
      SHIFT: begin
        state_d = LOAD;
        r0_d    = COL ? r0_q + 1 : r0_q;
        c0_d    = COL ? c0_q : c0_q + 1;
        ci_d    = COL ? 32'(SIZE - 1) : 32'd0;
        cj_d    = COL ? 32'd0 : 32'(SIZE - 1);
        iss_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    addr_d  = iss_d ? ADDR_W'((r0_d + ci_d) * IMG_W + c0_d + cj_d) : addr_q;
    wr_d    = iss_q;
    wi_d    = iss_q ? ci_q : 32'd0;
    wj_d    = iss_q ? cj_q : 32'd0;
    shift_d = state_d == SHIFT;
    valid_d = state_d == VALID;
    busy_d  = state_d != IDLE;
    done_d  = state_d == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      r0_q    <= '0;
      c0_q    <= '0;
      ci_q    <= '0;
      cj_q    <= '0;
      wi_q    <= '0;
      wj_q    <= '0;
      addr_q  <= '0;
      iss_q   <= 1'b0;
      wr_q    <= 1'b0;
      shift_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      c0_q    <= c0_d;
      ci_q    <= ci_d;
      cj_q    <= cj_d;
      wi_q    <= wi_d;
      wj_q    <= wj_d;
      addr_q  <= addr_d;
      iss_q   <= iss_d;
      wr_q    <= wr_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign memAddr   = addr_q;
  assign bufWrEn   = wr_q;
  assign bufDataIn = memData;
  assign bufIdxI   = valid_q ? rdIdxI : wi_q;
  assign bufIdxJ   = valid_q ? rdIdxJ : wj_q;
  assign winValid  = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule
